// File: rtl/lfsr_search_scheduler_if.sv
// lfsr_search_scheduler_if: request/result handshake bundle between capture channels and the scheduler.
interface lfsr_search_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [17*N_REQ-1:0] req_polynomial;
    logic [17*N_REQ-1:0] req_start;
    logic [17*N_REQ-1:0] req_target;
    logic                res_valid;
    logic                res_ready;
    logic [ID_W-1:0]     res_id;
    logic                res_found;
    logic [16:0]         res_offset;
    modport master (
        output req_valid, req_polynomial, req_start, req_target, res_ready,
        input  req_ready, res_valid, res_id, res_found, res_offset
    );
    modport slave (
        input  req_valid, req_polynomial, req_start, req_target, res_ready,
        output req_ready, res_valid, res_id, res_found, res_offset
    );
endinterface

// File: rtl/lfsr_search_scheduler.sv
// lfsr_search_scheduler: arbitrates N_REQ requesters onto one 17-bit lfsr and reports the match offset.
// Define LFSR_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module lfsr_search_scheduler #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MAX_ITER = 131071
) (
    input  logic                   clk_72MHz,
    input  logic                   rst_n,
    lfsr_search_scheduler_if.slave bus,
    output logic [16:0]            lfsr_polynomial,
    output logic [16:0]            lfsr_start_data,
    output logic                   lfsr_enable,
    input  logic [16:0]            lfsr_value,
    input  logic [16:0]            lfsr_iteration,
    output logic                   busy
);
    typedef enum logic [2:0] {IDLE, ARM, LOAD_WAIT, SEARCH, RESULT} state_t;
    state_t          state, state_nx;
    logic [16:0]     target;
    logic [ID_W-1:0] win;
    logic            grant_any;
    logic            hit;
    logic            last;
`ifdef LFSR_SCHED_RR_EN
    logic [ID_W-1:0] ptr;
`endif
    assign hit  = lfsr_value == target;
    assign last = lfsr_iteration == 17'(MAX_ITER - 1);
    // Descending scan so the candidate closest to the start of the order is assigned last and wins.
    always_comb begin
        win       = '0;
        grant_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
`ifdef LFSR_SCHED_RR_EN
            if (bus.req_valid[(int'(ptr) + i) % N_REQ]) begin
                win       = ID_W'((int'(ptr) + i) % N_REQ);
                grant_any = 1'b1;
            end
`else
            if (bus.req_valid[i]) begin
                win       = ID_W'(i);
                grant_any = 1'b1;
            end
`endif
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = grant_any ? ARM : IDLE;
            ARM:       state_nx = LOAD_WAIT;
            LOAD_WAIT: state_nx = SEARCH;
            SEARCH:    state_nx = (hit || last) ? RESULT : SEARCH;
            RESULT:    state_nx = bus.res_ready ? IDLE : RESULT;
            default:   state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            target          <= '0;
            lfsr_polynomial <= '0;
            lfsr_start_data <= '0;
            lfsr_enable     <= 1'b0;
            bus.req_ready   <= '0;
            bus.res_valid   <= 1'b0;
            bus.res_id      <= '0;
            bus.res_found   <= 1'b0;
            bus.res_offset  <= '0;
`ifdef LFSR_SCHED_RR_EN
            ptr             <= '0;
`endif
        end else begin
            state         <= state_nx;
            busy          <= state_nx != IDLE;
            bus.req_ready <= (state == IDLE && grant_any) ? N_REQ'(1) << win : '0;
            if (state == IDLE && grant_any) begin
                lfsr_polynomial <= bus.req_polynomial[17*win +: 17];
                lfsr_start_data <= bus.req_start[17*win +: 17];
                target          <= bus.req_target[17*win +: 17];
                bus.res_id      <= win;
                lfsr_enable     <= 1'b1;
`ifdef LFSR_SCHED_RR_EN
                ptr             <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
`endif
            end
            // A match on the exhaustion cycle still reports found.
            if (state == SEARCH && (hit || last)) begin
                bus.res_valid  <= 1'b1;
                bus.res_found  <= hit;
                bus.res_offset <= hit ? lfsr_iteration : 17'h1FFFF;
                lfsr_enable    <= 1'b0;
            end
            if (state == RESULT && bus.res_ready) bus.res_valid <= 1'b0;
        end
    end
endmodule
